// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the RISC-V multi-cycle fetch unit.
//   fetch_state_e : fetch FSM states (IDLE waits for a request, WAIT counts
//                   instruction-memory latency)
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) held in the IR after reset
//   PC_INCR       : sequential PC step, one 32-bit instruction word
package riscv_fetch_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/riscv_pc_reg.sv
// Program counter register with redirect, sequential increment and a sticky
// misalignment flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load the word-aligned part of target (redirect)
//   target     : redirect target; bits [1:0] only feed the misalign flag
//   incr       : advance the PC by one instruction (ignored when load is set)
//   pc         : current program counter, always word aligned
//   misalign   : set when the most recent redirect target was not word
//                aligned, cleared by the next aligned redirect
module riscv_pc_reg
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] target,
    input  logic        incr,
    output logic [31:0] pc,
    output logic        misalign
);

    logic [31:0] pc_q;
    logic        misalign_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order the statements execute in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else if (load) begin
            pc_q       <= {target[31:2], 2'b00};
            misalign_q <= |target[1:0];
        end else if (incr) begin
            // 32-bit add wraps 32'hFFFFFFFC to zero naturally.
            pc_q <= pc_q + PC_INCR;
        end
    end

    assign pc       = pc_q;
    assign misalign = misalign_q;

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch unit for a multi-cycle RISC-V core.
// A one-cycle request from the control unit starts a fetch at the current PC;
// the unit holds the address for IMEM_LATENCY cycles, captures the read data
// into the instruction register, advances (or redirects) the PC and pulses
// o_InstrValid for one cycle.
//   Clk, Rst        : clock, asynchronous active-low reset
//   i_FetchReq      : fetch request (ignored while busy)
//   i_PCWrite       : redirect the PC to i_PCNext
//   i_PCNext        : redirect target
//   i_RD            : instruction-memory read data
//   o_Addr          : instruction-memory byte address (the PC)
//   o_Instr         : instruction register
//   o_InstrPC       : PC of the instruction in o_Instr
//   o_InstrValid    : one-cycle pulse after o_Instr is updated
//   o_Busy          : fetch in progress
//   o_MisalignErr   : last redirect target was not word aligned
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        i_FetchReq,
    input  logic        i_PCWrite,
    input  logic [31:0] i_PCNext,
    input  logic [31:0] i_RD,
    output logic [31:0] o_Addr,
    output logic [31:0] o_Instr,
    output logic [31:0] o_InstrPC,
    output logic        o_InstrValid,
    output logic        o_Busy,
    output logic        o_MisalignErr
);

    localparam int CNT_W = $clog2(IMEM_LATENCY + 1);
    // Counter value at the edge before the one where it reaches IMEM_LATENCY.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_LATENCY - 1);

    fetch_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic            fetch_pend_q;
    logic            redir_pend_q;
    logic [31:0]     redir_tgt_q;
    logic [31:0]     instr_q;
    logic [31:0]     instr_pc_q;
    logic            instr_valid_q;

    logic [31:0]     pc;
    logic            pc_load;
    logic [31:0]     pc_target;
    logic            pc_incr;
    logic            start;
    logic            capture;

    // A redirect in IDLE takes priority for this edge; a request seen with it
    // is parked in fetch_pend_q so the fetch starts from the new PC.
    assign start   = (state_q == ST_IDLE) && (i_FetchReq || fetch_pend_q) && !i_PCWrite;
    assign capture = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)   state_d = ST_WAIT;
            ST_WAIT: if (capture) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // ---------------- PC control ----------------
    // At capture a redirect arriving on that very edge is the newest write and
    // beats the stored pending target.
    always_comb begin
        pc_load   = 1'b0;
        pc_target = i_PCNext;
        pc_incr   = 1'b0;
        if (state_q == ST_IDLE) begin
            pc_load = i_PCWrite;
        end else if (capture) begin
            if (i_PCWrite) begin
                pc_load = 1'b1;
            end else if (redir_pend_q) begin
                pc_load   = 1'b1;
                pc_target = redir_tgt_q;
            end else begin
                pc_incr = 1'b1;
            end
        end
    end

    riscv_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (Clk),
        .rst_n    (Rst),
        .load     (pc_load),
        .target   (pc_target),
        .incr     (pc_incr),
        .pc       (pc),
        .misalign (o_MisalignErr)
    );

    // ---------------- Counter, pending state, instruction register ----------------
    // NOTE: the instruction register is reset (to a NOP) rather than left
    // undefined, so a core released from reset never decodes garbage.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q         <= '0;
            fetch_pend_q  <= 1'b0;
            redir_pend_q  <= 1'b0;
            redir_tgt_q   <= '0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else begin
            instr_valid_q <= capture;
            if (capture) begin
                instr_q    <= i_RD;
                instr_pc_q <= pc;
            end

            if (state_q == ST_IDLE) begin
                fetch_pend_q <= i_PCWrite ? (i_FetchReq || fetch_pend_q) : 1'b0;
                if (start) cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (capture) begin
                    redir_pend_q <= 1'b0;
                end else if (i_PCWrite) begin
                    redir_pend_q <= 1'b1;
                    redir_tgt_q  <= i_PCNext;
                end
            end
        end
    end

    assign o_Addr       = pc;
    assign o_Instr      = instr_q;
    assign o_InstrPC    = instr_pc_q;
    assign o_InstrValid = instr_valid_q;
    assign o_Busy       = (state_q == ST_WAIT);

endmodule

// File: doc/riscv_fetch_unit.md
RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_LATENCY, default 2, meaning instruction-memory cycles from a stable address to valid read data (minimum 1).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Rst  input  1  asynchronous reset, active low.
REQ-006 i_FetchReq  input  1  one-cycle request from the multi-cycle control unit to fetch at the current PC.
REQ-007 i_PCWrite  input  1  load i_PCNext as the next PC (branch/jump redirect).
REQ-008 i_PCNext  input  32  redirect target.
REQ-009 i_RD  input  32  read data from the instruction memory.
REQ-010 o_Addr  output  32  byte address to the instruction memory; equal to the PC register at all times.
REQ-011 o_Instr  output  32  instruction register.
REQ-012 o_InstrPC  output  32  PC of the instruction held in o_Instr.
REQ-013 o_InstrValid  output  1  one-cycle pulse when o_Instr is updated.
REQ-014 o_Busy  output  1  high while a fetch is in progress.
REQ-015 o_MisalignErr  output  1  sticky flag: last redirect target had bits [1:0] non-zero.

Function
REQ-016 SHALL implement a state machine with states IDLE and WAIT; o_Busy = (state == WAIT).
REQ-017 IDLE with i_FetchReq=1 and i_PCWrite=0: go to WAIT and clear the latency counter.
REQ-018 In WAIT, the counter increments every cycle; at the edge where it reaches IMEM_LATENCY the unit captures i_RD into o_Instr, captures PC into o_InstrPC, pulses o_InstrValid in the following cycle, and returns to IDLE.
REQ-019 Request-to-valid latency SHALL be exactly IMEM_LATENCY cycles: request sampled at edge E0, o_Instr updated at edge E0+IMEM_LATENCY.
REQ-020 On capture, PC SHALL become PC+4 (mod 2^32; 32'hFFFFFFFC wraps to 0) unless a redirect is pending.
REQ-021 IDLE with i_PCWrite=1: PC loads {i_PCNext[31:2],2'b00}; o_MisalignErr is set if i_PCNext[1:0]!=0, otherwise cleared.
REQ-022 i_PCWrite and i_FetchReq together in IDLE: the redirect is applied at that edge; the fetch is held pending and WAIT is entered at the next edge, so the fetch uses the new PC.
REQ-023 i_PCWrite during WAIT: the target is stored in a pending-redirect register; the last write wins; at capture, PC loads the pending target instead of PC+4, and the pending register is cleared.
REQ-024 i_FetchReq during WAIT SHALL be ignored (no queueing); o_Busy is the control unit's indication.
REQ-025 o_Addr SHALL not change while in WAIT.
REQ-026 o_Instr and o_InstrPC SHALL hold their value between captures.

Reset
REQ-027 While Rst=0, regardless of the clock: PC=RESET_PC, state=IDLE, counter=0, no pending redirect or fetch, o_Instr=32'h00000013 (NOP), o_InstrPC=RESET_PC, o_InstrValid=0, o_Busy=0, o_MisalignErr=0.
REQ-028 Reset asserted mid-fetch SHALL abort the fetch with no o_InstrValid pulse; normal operation resumes from IDLE at the first edge after release.

Structure
REQ-029 Package riscv_fetch_pkg SHALL hold the state enumeration, the NOP constant 32'h00000013 and the PC increment constant 4.
REQ-030 A single sub-module, riscv_pc_reg (PC register with redirect, increment and misalign logic), is natural; the FSM and counter stay at top level.

Verification
REQ-031 Reset release, memory model with word0=32'h002081b3, i_FetchReq at E0 -> o_Instr=32'h002081b3, o_InstrPC=0 at E0+2; one-cycle o_InstrValid; o_Addr=4 afterwards.
REQ-032 Back-to-back fetches of words 0..3 -> o_InstrPC sequence 0,4,8,12; o_Busy high exactly 2 cycles per fetch.
REQ-033 i_PCWrite with i_PCNext=32'h30 plus i_FetchReq in the same cycle -> fetch at 0x30, o_Instr=word12, valid 3 cycles after the request.
REQ-034 i_PCWrite with 32'h40 during WAIT -> current fetch completes normally; PC=0x40 (not PC+4); a second write of 32'h50 in the same WAIT -> PC=0x50.
REQ-035 Redirect to 32'h00000006 -> PC=4, o_MisalignErr=1; a later redirect to 8 clears it. Redirect to 32'hFFFFFFFC followed by a fetch -> PC wraps to 0.
REQ-036 Rst low during WAIT -> no valid pulse, o_Instr=NOP, PC=RESET_PC immediately (asynchronous).
